ship_placer: RTL

SHIP_PLACER -- requirements
Module: ship_placer

---
 rtl/ship_placer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ship_placer.sv
// Ship placement stage of the battleship game.
// While placement is enabled, each confirm press (a 0->1 edge of the button)
// drops one ship on the cursor cell if that cell is on the board and still
// water; otherwise an error flag is raised and held for ERR_HOLD cycles.
// The stage finishes once the requested number of ships has been placed.
//
// Handshake note: there is no valid/ready pair here. confirm_btn is a level,
// and one event is taken on each rising edge of it. placement_en is a level
// that must stay high for the whole placement phase.
module ship_placer #(
  parameter int BOARD_N   = 5,
  parameter int MAX_SHIPS = 5,
  parameter int ERR_HOLD  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           placement_en,
  input  logic [2:0]                     i_cur,
  input  logic [2:0]                     j_cur,
  input  logic [2:0]                     ships_target,
  input  logic                           confirm_btn,
  output logic [2*BOARD_N*BOARD_N-1:0]   board_flat,
  output logic [2:0]                     ships_placed,
  output logic                           finished_placing,
  output logic                           placement_error,
  output logic [1:0]                     fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLACING = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int          CELLS  = BOARD_N * BOARD_N;
  localparam int          IDX_W  = $clog2(CELLS);
  localparam int          HOLD_W = $clog2(ERR_HOLD + 1);
  localparam logic [2:0]  MAX_T  = 3'(MAX_SHIPS);
  localparam logic [2:0]  N_3    = 3'(BOARD_N);

  state_t              state;
  state_t              state_next;
  logic                btn_q;
  logic [2:0]          target_q;
  logic [HOLD_W-1:0]   hold;

  logic                confirm_evt;
  logic [2:0]          target_clamped;
  logic                in_range;
  logic [IDX_W-1:0]    cell_idx;
  logic [1:0]          cell_val;
  logic                do_clear;
  logic                do_accept;
  logic                do_reject;

  assign confirm_evt      = confirm_btn & ~btn_q;
  assign target_clamped   = (ships_target > MAX_T) ? MAX_T : ships_target;
  assign in_range         = (i_cur < N_3) && (j_cur < N_3);
  assign cell_val         = board_flat[{cell_idx, 1'b0} +: 2];
  assign finished_placing = (state == DONE);
  assign fsm_state        = state;

  // Linear cell index of the cursor; forced to 0 when off-board so the
  // board lookup never addresses past the vector.
  always_comb begin
    int lin;
    lin      = int'(i_cur) * BOARD_N + int'(j_cur);
    cell_idx = in_range ? IDX_W'(lin) : '0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_next = state;
    do_clear   = 1'b0;
    do_accept  = 1'b0;
    do_reject  = 1'b0;
    case (state)
      IDLE: begin
        if (placement_en) begin
          do_clear   = 1'b1;
          state_next = (target_clamped == 3'd0) ? DONE : PLACING;
        end
      end
      PLACING: begin
        if (!placement_en) begin
          state_next = IDLE;
        end else if (confirm_evt) begin
          if (in_range && (cell_val == 2'b00)) begin
            do_accept = 1'b1;
            if (ships_placed + 3'd1 == target_q) state_next = DONE;
          end else begin
            do_reject = 1'b1;
          end
        end
      end
      DONE: begin
        if (!placement_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Board, ship count, target latch, error hold and button history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q           <= 1'b0;
      board_flat      <= '0;
      ships_placed    <= 3'd0;
      target_q        <= 3'd0;
      placement_error <= 1'b0;
      hold            <= '0;
    end else begin
      btn_q <= confirm_btn;
      if (do_clear) begin
        board_flat      <= '0;
        ships_placed    <= 3'd0;
        target_q        <= target_clamped;
        placement_error <= 1'b0;
        hold            <= '0;
      end else if (do_accept) begin
        board_flat[{cell_idx, 1'b0} +: 2] <= 2'b01;
        ships_placed    <= ships_placed + 3'd1;
        placement_error <= 1'b0;
        hold            <= '0;
      end else if (do_reject) begin
        placement_error <= 1'b1;
        hold            <= HOLD_W'(ERR_HOLD);
      end else if (hold != '0) begin
        hold            <= hold - HOLD_W'(1);
        placement_error <= (hold > HOLD_W'(1));
      end
    end
  end

endmodule
